alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Command issue stage sitting directly upstream of the SimpleALU. Buffers 16-bit ALU commands ({opcode, a, b, c} nibbles) from a loader in a small FIFO. Screens out illegal opcodes. Issues one command at a time on the ALU's 17-bit `command` bus, spacing issues so that MUL/DIV get a multi-cycle occupancy window.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- MULDIV_HOLD, 4, cycles the ALU is occupied per MUL/DIV; ≥1
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_cmd  in  16  command from loader: [15:12] opcode, [11:8] a, [7:4] b, [3:0] c
- in_valid  in  1  in_cmd valid
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready at a clock edge
- flush  in  1  synchronous discard of all queued and in-flight issue state
- command  out  17  to ALU: [16] issue strobe, [15:0] command word (registered)
- busy  out  1  FIFO non-empty or issue FSM not IDLE
- err_count  out  8  count of rejected illegal commands, saturating

## Operation
- Legal opcodes: STO=1, ADD=2, SUB=3, MUL=4, DIV=5. Opcodes 0 and 6–15 are illegal.
- Input side:
  - in_ready = (count != DEPTH). It depends only on count, not on a same-cycle pop.
  - A legal accepted command is pushed.
  - An illegal accepted command is consumed (handshake completes) but not pushed. err_count increments and saturates at 255.
- FIFO: circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, plus a count of 0..DEPTH. Push and pop in the same cycle is allowed when count is between 1 and DEPTH-1; count is unchanged.
- Issue FSM:
  - IDLE: if count≠0, pop the head, load command[15:0] with it, pulse command[16]=1 for one cycle, and go to HOLD with hold_cnt = occupancy-1. Occupancy is 1 for STO/ADD/SUB and MULDIV_HOLD for MUL/DIV. If occupancy is 1, stay in IDLE (back-to-back issue allowed).
  - HOLD: command[16]=0. Decrement hold_cnt each cycle. Go to IDLE when hold_cnt reaches 0 — on that edge, not issuing. The next issue is earliest at the following edge.
- command[15:0] holds the last issued word until the next issue. command[16] is high for exactly one cycle per issued command.
- busy = (count≠0) | (state≠IDLE).
- flush (when rst is low):
  - Clears count and pointers.
  - Forces IDLE and sets command to 17'h0.
  - No push occurs that cycle, regardless of in_valid; in_ready still shows the pre-flush value.
  - err_count is unchanged.
- rst: count=0, pointers=0, state=IDLE, command=17'h0, err_count=0. rst has priority over flush and all other inputs.

## Timing
- Reset values: in_ready=1, command=17'h0, busy=0, err_count=0.
- Latency: command accepted at edge N into an empty FIFO with FSM IDLE → command[16]=1 during cycle N+1..N+2 (popped at edge N+1). Minimum latency is 1 cycle.
- STO/ADD/SUB stream: one issue per cycle when the FIFO stays non-empty.
- MUL/DIV at edge K → next issue no earlier than edge K+MULDIV_HOLD.
- Full: count=DEPTH → in_ready=0 even if a pop occurs that cycle. in_ready rises the cycle after a pop.
- Reset or flush mid-HOLD aborts the hold. The next command can issue on the edge after a new push.
- err_count at 255 stays 255 while illegal commands continue to be accepted.

## Test plan
- Reset, then push 16'h1200, 16'h1050, 16'h1140 back-to-back → command[16] pulses on three consecutive cycles, carrying 1200, 1050, 1140; busy then falls; err_count=0.
- MULDIV_HOLD=4: push 16'h4110 then 16'h2221 → 17'h1_4110 issued; strobe low 3 cycles; 17'h1_2221 issued exactly 4 cycles after the MUL.
- Push 16'h0123, 16'h7000, 16'hF111 → all accepted (in_ready=1), none issued, err_count=3. Push 256 illegal commands → err_count stays 255.
- Stall consumer with DIV 16'h5000 (MULDIV_HOLD=8) and push DEPTH+1 legal commands → in_ready=0 when count=8; 9th held until a pop; order preserved across pointer wrap.
- Assert flush during HOLD with 3 queued commands → next cycle command=17'h0, busy=0, in_ready=1, err_count unchanged; nothing further issued.
- Assert rst during issue with flush also high → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command issue stage in front of the SimpleALU.
// Buffers 16-bit ALU commands ({opcode, a, b, c}) in a circular FIFO, drops illegal
// opcodes (counting them), and issues one command at a time on the registered 17-bit
// command bus. MUL/DIV keep the issue path occupied for MULDIV_HOLD cycles.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset, priority over everything
//   in_cmd     command from loader: [15:12] opcode, [11:8] a, [7:4] b, [3:0] c
//   in_valid   in_cmd valid
//   in_ready   stage can accept (FIFO not full)
//   flush      synchronous discard of queued and in-flight issue state
//   command    [16] one-cycle issue strobe, [15:0] last issued command word
//   busy       FIFO non-empty or issue FSM holding
//   err_count  saturating count of rejected illegal commands
module alu_cmd_issue #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned MULDIV_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_cmd,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [16:0] command,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned HoldW = (MULDIV_HOLD > 1) ? $clog2(MULDIV_HOLD) : 1;

   localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);
   localparam logic [HoldW-1:0] HoldInit = HoldW'(MULDIV_HOLD - 1);
   localparam bit               LongOcc  = (MULDIV_HOLD > 1);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e            state_q, state_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [15:0]       mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [16:0]       command_q, command_d;
   logic [7:0]        err_q, err_d;

   logic [15:0] head;
   logic        head_muldiv;
   logic        in_legal;
   logic        accept;
   logic        push;
   logic        pop;

   // Legal opcodes are STO=1, ADD=2, SUB=3, MUL=4, DIV=5.
   assign in_legal    = (in_cmd[15:12] >= 4'd1) && (in_cmd[15:12] <= 4'd5);
   assign head        = mem_q[rd_ptr_q];
   assign head_muldiv = (head[15:12] == 4'd4) || (head[15:12] == 4'd5);

   // in_ready is a function of count alone, so a full FIFO stays closed even on a pop cycle.
   assign in_ready = (count_q != CntFull);
   assign accept   = in_valid && in_ready;
   assign push     = accept && in_legal && !flush;

   // ---------------------------------------------------------------------------------------
   // Issue FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Issue FSM: next state
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (flush) begin
         state_d = StIdle;
         hold_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Single-cycle ops stay in StIdle so they can issue back to back.
               if ((count_q != '0) && head_muldiv && LongOcc) begin
                  state_d = StHold;
                  hold_d  = HoldInit;
               end
            end
            StHold: begin
               // The edge where hold_cnt reaches 0 returns to idle without issuing.
               if (hold_q <= HoldW'(1)) begin
                  state_d = StIdle;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q - HoldW'(1);
               end
            end
            default: begin
               state_d = StIdle;
               hold_d  = '0;
            end
         endcase
      end
   end

   // Issue FSM: outputs (pop and the next registered command word)
   always_comb begin
      pop       = (state_q == StIdle) && (count_q != '0) && !flush;
      command_d = {1'b0, command_q[15:0]};
      if (flush) begin
         command_d = '0;
      end else if (pop) begin
         command_d = {1'b1, head};
      end
   end

   // ---------------------------------------------------------------------------------------
   // FIFO bookkeeping and error counter
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
         if (accept && !in_legal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         command_q <= '0;
         err_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         command_q <= command_d;
         err_q     <= err_d;
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_cmd;
      end
   end

   assign command   = command_q;
   assign busy      = (count_q != '0) || (state_q != StIdle);
   assign err_count = err_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue (DEPTH=8, MULDIV_HOLD=4). Issued commands are logged
// on the falling edge with a cycle stamp and compared against hand-derived sequences.
module tb_alu_cmd_issue;

   logic        clk;
   logic        rst;
   logic [15:0] in_cmd;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [16:0] command;
   logic        busy;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_errs   = 0;
   int stalled  = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic [16:0] w;
   } ent_t;
   ent_t issue_q[$];

   alu_cmd_issue #(
      .DEPTH       (8),
      .MULDIV_HOLD (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_cmd    (in_cmd),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .command   (command),
      .busy      (busy),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      ent_t e;
      cyc = cyc + 1;
      if (command[16]) begin
         e.cyc = cyc;
         e.w   = command;
         issue_q.push_back(e);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] log_w(input int i);
      if (i < issue_q.size()) return {15'b0, issue_q[i].w};
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int log_c(input int i);
      if (i < issue_q.size()) return issue_q[i].cyc;
      return -1000;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one command; waits (bounded) while in_ready is low, counting stall cycles.
   task automatic push(input logic [15:0] c);
      int n;
      n        = 0;
      in_cmd   = c;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         stalled++;
         n++;
         tick(1);
      end
      if (n >= 200) check_val("push_timeout", 32'd0, 32'd1);
      tick(1);
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_cmd   = '0;
      tick(2);
      rst = 1'b0;

      // Reset state
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_command", command, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_err", err_count, 0);

      // Back-to-back STO stream
      issue_q.delete();
      push(16'h1200);
      push(16'h1050);
      push(16'h1140);
      tick(4);
      check_val("sto_n", issue_q.size(), 3);
      check_val("sto_w0", log_w(0), 32'h1_1200);
      check_val("sto_w1", log_w(1), 32'h1_1050);
      check_val("sto_w2", log_w(2), 32'h1_1140);
      check_val("sto_gap01", log_c(1) - log_c(0), 1);
      check_val("sto_gap12", log_c(2) - log_c(1), 1);
      check_val("sto_busy", busy, 0);
      check_val("sto_err", err_count, 0);

      // MUL occupancy window
      issue_q.delete();
      push(16'h4110);
      push(16'h2221);
      tick(10);
      check_val("mul_n", issue_q.size(), 2);
      check_val("mul_w0", log_w(0), 32'h1_4110);
      check_val("mul_w1", log_w(1), 32'h1_2221);
      check_val("mul_gap", log_c(1) - log_c(0), 4);

      // Illegal opcodes and saturation
      issue_q.delete();
      check_val("ill_rdy0", in_ready, 1);
      push(16'h0123);
      check_val("ill_rdy1", in_ready, 1);
      push(16'h7000);
      check_val("ill_rdy2", in_ready, 1);
      push(16'hF111);
      tick(4);
      check_val("ill_n", issue_q.size(), 0);
      check_val("ill_err3", err_count, 3);
      check_val("ill_busy", busy, 0);
      for (int i = 0; i < 252; i++) push(16'h8000 | 16'(i));
      check_val("ill_err255", err_count, 255);
      for (int i = 0; i < 4; i++) push(16'hE000);
      check_val("ill_sat", err_count, 255);
      check_val("ill_n2", issue_q.size(), 0);

      // Full FIFO behind a chain of DIVs; write pointer wraps
      issue_q.delete();
      stalled = 0;
      for (int i = 0; i < 12; i++) push(16'h5000 + 16'(i));
      check_val("full_stall", stalled, 3);
      tick(40);
      check_val("full_n", issue_q.size(), 12);
      for (int i = 0; i < 12; i++) begin
         check_val($sformatf("full_w%0d", i), log_w(i), 32'h1_5000 + i);
      end
      check_val("full_busy", busy, 0);

      // Flush during HOLD with three queued commands
      issue_q.delete();
      push(16'h4000);
      push(16'h2001);
      push(16'h2002);
      push(16'h2003);
      check_val("fl_busy_pre", busy, 1);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_cmd   = 16'h2004;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      check_val("fl_command", command, 0);
      check_val("fl_busy", busy, 0);
      check_val("fl_in_ready", in_ready, 1);
      check_val("fl_err", err_count, 255);
      tick(10);
      check_val("fl_n", issue_q.size(), 1);
      check_val("fl_w0", log_w(0), 32'h1_4000);

      // Reset with flush also high, mid-issue
      issue_q.delete();
      push(16'h4ABC);
      push(16'h2DEF);
      check_val("rf_cmd_pre", command, 32'h1_4ABC);
      check_val("rf_busy_pre", busy, 1);
      rst      = 1'b1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_cmd   = 16'h0000;
      tick(1);
      rst      = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      check_val("rf_in_ready", in_ready, 1);
      check_val("rf_command", command, 0);
      check_val("rf_busy", busy, 0);
      check_val("rf_err", err_count, 0);
      tick(8);
      check_val("rf_n", issue_q.size(), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
